demux1x4_reg: RTL and testbench
===============================

Name: demux1x4_reg

Overview:
- Registered 1-to-N demultiplexer: the distribution counterpart of the team's 2:1 selector.
- Routes one input word to the output lane addressed by SEL, with an active-low enable Gbar.
- Each lane has a one-entry output register and a valid/ready handshake.
- Sits between a single producer and N independent consumers, e.g. the back end of a selector-fed datapath.

Parameters:
- W, 8, data word width in bits.
- N, 4, number of output lanes; must be a power of two, 2..16.
- SELW, $clog2(N), localparam (derived, not overridable): SEL width.

Ports:
- CLK  input  1  rising-edge clock.
- RSTbar  input  1  reset, asynchronous, active-low.
- Gbar  input  1  enable, active-low; when 1, no new word is accepted.
- DIN  input  W  input data word.
- SEL  input  SELW  destination lane index.
- VIN  input  1  DIN/SEL valid.
- RDY_IN  output  1  block can accept the word offered this cycle.
- Y  output  N*W  lane data; lane k occupies bits [k*W +: W].
- VOUT  output  N  per-lane valid.
- RDY  input  N  per-lane downstream ready.

Behaviour:
- Reset (RSTbar=0, asynchronous): VOUT=0 and Y=0 on all lanes, applied immediately and held while RSTbar is low. A word held mid-transfer is discarded.
- Per-lane state machine, two states:
  - EMPTY (VOUT[k]=0) and FULL (VOUT[k]=1).
  - EMPTY -> FULL on accept to lane k.
  - FULL -> EMPTY on drain (VOUT[k] & RDY[k]) with no accept the same cycle.
  - FULL -> FULL when drain and accept occur the same cycle; the new word replaces the old.
- Ready: RDY_IN = !Gbar & (!VOUT[SEL] | RDY[SEL]). This is combinational from SEL, Gbar, VOUT and RDY, and does not depend on VIN.
- Accept: VIN & RDY_IN at a rising CLK edge.
  - Y lane SEL is loaded with DIN and VOUT[SEL] is set.
  - Latency 1 cycle, from the accepting edge to VOUT high.
  - Full throughput: one word per cycle per lane when that lane's RDY is held high.
- Non-selected lanes are unaffected by DIN and SEL. They drain independently: each lane with VOUT[k] & RDY[k] clears that cycle unless it is also the accept target.
- Gbar=1: RDY_IN=0 and no accept. FULL lanes still drain, and held Y values remain stable.
- A Gbar rise in the same cycle as VIN blocks the word; the upstream side must hold it.
- Lane data: Y[k] holds its value while VOUT[k]=1 and RDY[k]=0. After a drain, Y[k] keeps its last value (not cleared).
- VIN=1 with Gbar=0 and target lane FULL with RDY low: RDY_IN=0 and the word stalls; no other lane is affected.
- Changing SEL while VIN=1 and RDY_IN=0 is a protocol violation. Behaviour is undefined but must not corrupt other lanes.

Optional Feature:
- Macro: DEMUX1X4_CNT_EN.
- Defined:
  - Adds output port CNT (N*8 bits): an 8-bit counter per lane, incremented on each drain (VOUT[k] & RDY[k]).
  - Counters wrap 255 -> 0 and reset to 0 on RSTbar.
  - Adds input CNT_CLR (1 bit): synchronous clear of all counters. If a clear and a drain occur in the same cycle, the counter goes to 0.
- Not defined: no CNT or CNT_CLR ports and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package/header: lane state encodings (LANE_EMPTY=1'b0, LANE_FULL=1'b1), the counter width constant CNT_W=8, and the default W and N.
- One natural sub-module, demux_lane:
  - Holds the one-entry register and valid for a single lane.
  - Inputs: load, data, drain.
  - Outputs: Y slice and VOUT bit.
  - Instantiated N times in a generate loop.
- The top level holds the SEL decode, RDY_IN logic and optional counters.

Test Plan:
- Reset check: RSTbar=0 mid-run with lanes 1 and 3 FULL -> VOUT=4'b0000 and Y=0 immediately, without waiting for CLK; after release, RDY_IN=1 for any SEL with Gbar=0.
- Basic routing (RDY=4'b1111): DIN=8'hA5, SEL=2, VIN=1, Gbar=0 for one cycle -> next cycle VOUT=4'b0100, Y[23:16]=8'hA5, other lanes unchanged.
- Backpressure: RDY[1]=0; send 8'h11 then 8'h22 to SEL=1 -> first accepted, RDY_IN=0 on the second; raise RDY[1] -> 8'h11 drains, 8'h22 is accepted the same cycle, VOUT[1] stays 1.
- Enable gating: Gbar=1, VIN=1, DIN=8'h3C, SEL=0 -> RDY_IN=0 and VOUT[0] stays 0; lane 2 FULL with RDY[2]=1 still drains.
- Throughput: RDY all 1, Gbar=0; stream 16 words with SEL cycling 0..3 -> 16 consecutive accepts, each lane receives 4 words in order, each VOUT pulse 1 cycle after its accept.
- DEMUX1X4_CNT_EN defined: 260 drains on lane 3 -> CNT lane 3 = 4 (wrapped); assert CNT_CLR with a simultaneous drain -> 0.

Source files
------------

// File: rtl/demux1x4_reg_pkg.sv
// Shared constants and lane-state encoding for the registered 1-to-N demultiplexer.
package demux1x4_reg_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 4;
  localparam int CNT_W = 8;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

endpackage

// File: rtl/demux1x4_reg_demux_lane.sv
// One output lane: a one-entry data register plus its EMPTY/FULL valid state.
//
// state      | meaning
// LANE_EMPTY | no word held, o_vout=0, o_y keeps the last drained word
// LANE_FULL  | word held in o_y, o_vout=1 until drained
module demux_lane
  import demux1x4_reg_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_drain,
  output logic [W-1:0] o_y,
  output logic         o_vout
);

  lane_state_e  r_state;
  logic [W-1:0] r_data;

  // A load in the same cycle as a drain overwrites the word and stays FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LANE_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        LANE_EMPTY: begin
          if (i_load) begin
            r_data  <= i_data;
            r_state <= LANE_FULL;
          end
        end
        LANE_FULL: begin
          if (i_load) begin
            r_data <= i_data;
          end else if (i_drain) begin
            r_state <= LANE_EMPTY;
          end
        end
        default: r_state <= LANE_EMPTY;
      endcase
    end
  end

  assign o_y    = r_data;
  assign o_vout = (r_state == LANE_FULL);

endmodule

// File: rtl/demux1x4_reg.sv
// Registered 1-to-N demultiplexer with per-lane valid/ready handshake.
// Optional per-lane drain counters are enabled by defining DEMUX1X4_CNT_EN.
module demux1x4_reg
  import demux1x4_reg_pkg::*;
#(
  parameter  int W    = DEF_W,
  parameter  int N    = DEF_N,
  localparam int SELW = $clog2(N)
) (
  input  logic              CLK,
  input  logic              RSTbar,
  input  logic              Gbar,
  input  logic [W-1:0]      DIN,
  input  logic [SELW-1:0]   SEL,
  input  logic              VIN,
  output logic              RDY_IN,
  output logic [N*W-1:0]    Y,
  output logic [N-1:0]      VOUT,
  input  logic [N-1:0]      RDY
`ifdef DEMUX1X4_CNT_EN
  ,
  output logic [N*CNT_W-1:0] CNT,
  input  logic               CNT_CLR
`endif
);

  logic         w_accept;
  logic [N-1:0] w_load;
  logic [N-1:0] w_drain;

  // Ready ignores VIN so the producer can see it before committing a word.
  assign RDY_IN   = !Gbar && (!VOUT[SEL] || RDY[SEL]);
  assign w_accept = VIN && RDY_IN;
  assign w_load   = w_accept ? (N'(1) << SEL) : '0;
  assign w_drain  = VOUT & RDY;

  for (genvar k = 0; k < N; k++) begin : g_lane
    demux_lane #(
      .W (W)
    ) u_lane (
      .clk     (CLK),
      .rst_n   (RSTbar),
      .i_load  (w_load[k]),
      .i_data  (DIN),
      .i_drain (w_drain[k]),
      .o_y     (Y[k*W +: W]),
      .o_vout  (VOUT[k])
    );
  end

`ifdef DEMUX1X4_CNT_EN
  for (genvar k = 0; k < N; k++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    // Clear wins over a simultaneous drain; counting wraps naturally.
    always_ff @(posedge CLK or negedge RSTbar) begin
      if (!RSTbar) begin
        r_cnt <= '0;
      end else if (CNT_CLR) begin
        r_cnt <= '0;
      end else if (w_drain[k]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign CNT[k*CNT_W +: CNT_W] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_demux1x4_reg.sv
// Scoreboard bench for demux1x4_reg: stimulus pushes expected words per lane,
// a negedge monitor pops and compares on every drain (VOUT & RDY).
module tb_demux1x4_reg;

  localparam int W = 8;
  localparam int N = 4;

  logic           CLK;
  logic           RSTbar;
  logic           Gbar;
  logic [W-1:0]   DIN;
  logic [1:0]     SEL;
  logic           VIN;
  logic           RDY_IN;
  logic [N*W-1:0] Y;
  logic [N-1:0]   VOUT;
  logic [N-1:0]   RDY;
`ifdef DEMUX1X4_CNT_EN
  logic [N*8-1:0] CNT;
  logic           CNT_CLR;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] sb_q [N][$];

  demux1x4_reg dut (
    .CLK     (CLK),
    .RSTbar  (RSTbar),
    .Gbar    (Gbar),
    .DIN     (DIN),
    .SEL     (SEL),
    .VIN     (VIN),
    .RDY_IN  (RDY_IN),
    .Y       (Y),
    .VOUT    (VOUT),
    .RDY     (RDY)
`ifdef DEMUX1X4_CNT_EN
    ,
    .CNT     (CNT),
    .CNT_CLR (CNT_CLR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [W-1:0] din);
    SEL = sel;
    DIN = din;
    VIN = 1'b1;
    #1;
  endtask

  // Offer a word that must be accepted at the next edge.
  task automatic send(input logic [1:0] sel, input logic [W-1:0] din);
    drive(sel, din);
    check("rdy_in_send", 32'(RDY_IN), 32'd1);
    sb_q[sel].push_back(din);
    tick();
  endtask

  always @(negedge CLK) begin
    if (RSTbar) begin
      for (int k = 0; k < N; k++) begin
        if (VOUT[k] && RDY[k]) begin
          if (sb_q[k].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_unexpected: lane %0d got %0h expected none", k, Y[k*W +: W]);
          end else begin
            check($sformatf("drain_lane%0d", k), 32'(Y[k*W +: W]), 32'(sb_q[k].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTbar = 1'b0;
    Gbar   = 1'b1;
    DIN    = '0;
    SEL    = '0;
    VIN    = 1'b0;
    RDY    = '0;
`ifdef DEMUX1X4_CNT_EN
    CNT_CLR = 1'b0;
`endif
    tick();
    tick();
    check("reset_vout", 32'(VOUT), 32'd0);
    check("reset_y", Y, 32'd0);
    RSTbar = 1'b1;
    tick();
    Gbar = 1'b0;
    for (int s = 0; s < N; s++) begin
      SEL = 2'(s);
      #1;
      check("rdy_in_after_reset", 32'(RDY_IN), 32'd1);
    end
    tick();

    // Basic routing
    RDY = 4'b1111;
    send(2'd2, 8'hA5);
    VIN = 1'b0;
    check("route_vout", 32'(VOUT), 32'h4);
    check("route_y2", 32'(Y[23:16]), 32'hA5);
    check("route_others", 32'({Y[31:24], Y[15:0]}), 32'd0);
    tick();
    check("route_drained", 32'(VOUT), 32'd0);

    // Backpressure on lane 1
    RDY = 4'b1101;
    send(2'd1, 8'h11);
    drive(2'd1, 8'h22);
    check("bp_stall_rdy_in", 32'(RDY_IN), 32'd0);
    tick();
    check("bp_hold_vout", 32'(VOUT[1]), 32'd1);
    check("bp_hold_y", 32'(Y[15:8]), 32'h11);
    RDY[1] = 1'b1;
    #1;
    check("bp_release_rdy_in", 32'(RDY_IN), 32'd1);
    sb_q[1].push_back(8'h22);
    tick();
    VIN = 1'b0;
    check("bp_replace_vout", 32'(VOUT[1]), 32'd1);
    check("bp_replace_y", 32'(Y[15:8]), 32'h22);
    tick();
    check("bp_empty", 32'(VOUT), 32'd0);

    // Enable gating while lane 2 drains
    RDY = 4'b1011;
    send(2'd2, 8'h77);
    VIN = 1'b0;
    Gbar = 1'b1;
    RDY[2] = 1'b1;
    drive(2'd0, 8'h3C);
    check("gate_rdy_in", 32'(RDY_IN), 32'd0);
    tick();
    check("gate_vout", 32'(VOUT), 32'd0);
    check("gate_y0", 32'(Y[7:0]), 32'd0);
    check("gate_y2_kept", 32'(Y[23:16]), 32'h77);
    VIN = 1'b0;
    Gbar = 1'b0;
    tick();

    // Throughput: 16 back-to-back words cycling lanes
    RDY = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      send(2'(i % 4), 8'(8'h40 + i));
      check("tp_vout", 32'(VOUT[i % 4]), 32'd1);
      check("tp_y", 32'(Y[(i % 4)*W +: W]), 32'(8'h40 + i));
    end
    VIN = 1'b0;
    tick();
    tick();

    // Asynchronous reset mid-run with lanes 1 and 3 full
    RDY = 4'b0000;
    send(2'd1, 8'h55);
    send(2'd3, 8'h99);
    VIN = 1'b0;
    check("pre_reset_vout", 32'(VOUT), 32'hA);
    #2;
    RSTbar = 1'b0;
    #1;
    check("async_reset_vout", 32'(VOUT), 32'd0);
    check("async_reset_y", Y, 32'd0);
    sb_q[1].delete();
    sb_q[3].delete();
    tick();
    RSTbar = 1'b1;
    for (int s = 0; s < N; s++) begin
      SEL = 2'(s);
      #1;
      check("rdy_in_after_async_reset", 32'(RDY_IN), 32'd1);
    end
    tick();

`ifdef DEMUX1X4_CNT_EN
    RDY = 4'b1111;
    for (int i = 0; i < 260; i++) send(2'd3, 8'(i));
    VIN = 1'b0;
    tick();
    check("cnt_lane3_wrap", 32'(CNT[31:24]), 32'd4);
    check("cnt_lane1_idle", 32'(CNT[15:8]), 32'd0);
    send(2'd3, 8'hEE);
    VIN = 1'b0;
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    check("cnt_clr_with_drain", 32'(CNT[31:24]), 32'd0);
    tick();
    check("cnt_after_clr", 32'(CNT[31:24]), 32'd0);
`endif

    tick();
    tick();
    for (int k = 0; k < N; k++) check($sformatf("sb_empty_lane%0d", k), 32'(sb_q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
